nios_system_sysid_checker: RTL

NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: nios_system_sysid_checker

---
 rtl/nios_system_sysid_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker
//   Reads the two words of a sysid control slave over Avalon-MM (word 0 = ID,
//   word 1 = timestamp) and compares them against the values this build
//   expects. Each read is guarded by a cycle-count timeout.
//
// Ports
//   clock, reset_n        : clock and asynchronous active-low reset
//   start                 : one-cycle request to run a check (ignored while busy)
//   avm_address/avm_read  : read request to the sysid slave
//   avm_waitrequest       : slave stall; request accepted when read & !waitrequest
//   avm_readdatavalid     : qualifies avm_readdata
//   avm_readdata          : read response data
//   busy                  : a check is in progress
//   done                  : check finished, held until the next accepted start
//   pass                  : both words matched (valid while done=1)
//   timeout_err           : a read exceeded TIMEOUT_CYCLES
//   id_value, timestamp_value : the captured words
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1674984379,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          START_ON_RESET     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        boot;      // pending automatic start after reset release
  logic        launch;
  logic        accept;
  logic        limit;
  logic        tmo_fire;

  assign launch = ((state == IDLE) || (state == DONE)) && (start || boot);
  assign accept = avm_read && !avm_waitrequest;
  assign limit  = (cnt >= TMO_LIMIT);

  // The completing event of a phase beats a timeout that lands on the same cycle.
  always_comb begin
    tmo_fire = 1'b0;
    case (state)
      ID_REQ, TS_REQ:   tmo_fire = limit && !accept;
      ID_WAIT, TS_WAIT: tmo_fire = limit && !avm_readdatavalid;
      default:          tmo_fire = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (launch) state_nxt = ID_REQ;
      ID_REQ:  if (accept)            state_nxt = ID_WAIT;
               else if (tmo_fire)     state_nxt = DONE;
      ID_WAIT: if (avm_readdatavalid) state_nxt = TS_REQ;
               else if (tmo_fire)     state_nxt = DONE;
      TS_REQ:  if (accept)            state_nxt = TS_WAIT;
               else if (tmo_fire)     state_nxt = DONE;
      TS_WAIT: if (avm_readdatavalid || tmo_fire) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs; address and read stay fixed for the whole REQ state
  always_comb begin
    busy        = 1'b0;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    case (state)
      ID_REQ:  begin busy = 1'b1; avm_read = 1'b1; end
      ID_WAIT: busy = 1'b1;
      TS_REQ:  begin busy = 1'b1; avm_read = 1'b1; avm_address = 1'b1; end
      TS_WAIT: busy = 1'b1;
      default: ;
    endcase
  end

  // Reset loads START_ON_RESET so the first cycle after release acts as a start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) boot <= START_ON_RESET;
    else          boot <= 1'b0;
  end

  // Per-transaction cycle counter: restarts on entry to each REQ state,
  // runs across REQ+WAIT, saturates rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if ((state_nxt == ID_REQ && state != ID_REQ) ||
             (state_nxt == TS_REQ && state != TS_REQ))
      cnt <= '0;
    else if (busy && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  // captured words and result flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout_err     <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else if (launch) begin
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout_err     <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      if (state == ID_WAIT && avm_readdatavalid)
        id_value <= avm_readdata;
      if (state == TS_WAIT && avm_readdatavalid) begin
        timestamp_value <= avm_readdata;
        done            <= 1'b1;
        // id_value already holds word 0; word 1 is compared as it arrives
        pass            <= (id_value == EXPECTED_ID) &&
                           (avm_readdata == EXPECTED_TIMESTAMP);
        timeout_err     <= 1'b0;
      end else if (tmo_fire) begin
        done        <= 1'b1;
        pass        <= 1'b0;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
